// File: rtl/ttt_game_controller.sv
// Tic-tac-toe turn sequencer: owns the 3x3 grid, alternates players, detects win/draw, keeps scores.
// Optional TTT_WIN_HIGHLIGHT_EN marks the first winning line with code 11 on entry to WIN.
module ttt_game_controller #(
  parameter logic [3:0] RESTART_KEY = 4'd0,
  parameter logic [3:0] SCORE_MAX   = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] a9,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       illegal,
  output logic [3:0] x_score,
  output logic [3:0] o_score
);

  typedef enum logic [1:0] {StPlay, StCheck, StWin, StDraw} state_e;

  localparam logic [1:0] PlayerX = 2'b01;
  localparam logic [1:0] PlayerO = 2'b10;

  state_e          state_q, state_d;
  logic [8:0][1:0] cells_q, cells_d;
  logic [3:0]      move_q, move_d;
  logic [1:0]      turn_q, turn_d;
  logic [1:0]      winner_q, winner_d;
  logic            illegal_q, illegal_d;
  logic [3:0]      x_score_q, x_score_d;
  logic [3:0]      o_score_q, o_score_d;

  logic [8:0] key_hot;
  logic [8:0] empty;
  logic [7:0] line_hit;

  function automatic logic line_eq(input logic [1:0] x, input logic [1:0] y,
                                   input logic [1:0] z);
    return (x != 2'b00) && (x == y) && (y == z);
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      key_hot[i] = (key_code == 4'(i + 1));
      empty[i]   = (cells_q[i] == 2'b00);
    end
  end

  // Line order matters: it is the priority used for highlighting.
  always_comb begin
    line_hit[0] = line_eq(cells_q[0], cells_q[1], cells_q[2]);
    line_hit[1] = line_eq(cells_q[3], cells_q[4], cells_q[5]);
    line_hit[2] = line_eq(cells_q[6], cells_q[7], cells_q[8]);
    line_hit[3] = line_eq(cells_q[0], cells_q[3], cells_q[6]);
    line_hit[4] = line_eq(cells_q[1], cells_q[4], cells_q[7]);
    line_hit[5] = line_eq(cells_q[2], cells_q[5], cells_q[8]);
    line_hit[6] = line_eq(cells_q[0], cells_q[4], cells_q[8]);
    line_hit[7] = line_eq(cells_q[2], cells_q[4], cells_q[6]);
  end

`ifdef TTT_WIN_HIGHLIGHT_EN
  logic [8:0] win_mask;

  always_comb begin
    win_mask = 9'b0;
    if      (line_hit[0]) win_mask = 9'b000000111;
    else if (line_hit[1]) win_mask = 9'b000111000;
    else if (line_hit[2]) win_mask = 9'b111000000;
    else if (line_hit[3]) win_mask = 9'b001001001;
    else if (line_hit[4]) win_mask = 9'b010010010;
    else if (line_hit[5]) win_mask = 9'b100100100;
    else if (line_hit[6]) win_mask = 9'b100010001;
    else if (line_hit[7]) win_mask = 9'b001010100;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    move_d    = move_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
    x_score_d = x_score_q;
    o_score_d = o_score_q;
    unique case (state_q)
      StPlay: begin
        if (key_valid) begin
          // key_hot is zero for codes outside 1..9, so those fall through as illegal.
          if ((key_code != RESTART_KEY) && |(key_hot & empty)) begin
            for (int i = 0; i < 9; i++) begin
              if (key_hot[i]) cells_d[i] = turn_q;
            end
            move_d  = move_q + 4'd1;
            state_d = StCheck;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StCheck: begin
        if (|line_hit) begin
          state_d  = StWin;
          winner_d = turn_q;
          turn_d   = 2'b00;
          if (turn_q == PlayerX && x_score_q < SCORE_MAX) x_score_d = x_score_q + 4'd1;
          if (turn_q == PlayerO && o_score_q < SCORE_MAX) o_score_d = o_score_q + 4'd1;
`ifdef TTT_WIN_HIGHLIGHT_EN
          for (int i = 0; i < 9; i++) begin
            if (win_mask[i]) cells_d[i] = 2'b11;
          end
`endif
        end else if (move_q == 4'd9) begin
          state_d  = StDraw;
          winner_d = 2'b00;
          turn_d   = 2'b00;
        end else begin
          turn_d  = (turn_q == PlayerX) ? PlayerO : PlayerX;
          state_d = StPlay;
        end
      end
      StWin, StDraw: begin
        if (key_valid && key_code == RESTART_KEY) begin
          cells_d  = '0;
          move_d   = 4'd0;
          winner_d = 2'b00;
          turn_d   = PlayerX;
          state_d  = StPlay;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StPlay;
      cells_q   <= '0;
      move_q    <= 4'd0;
      turn_q    <= PlayerX;
      winner_q  <= 2'b00;
      illegal_q <= 1'b0;
      x_score_q <= 4'd0;
      o_score_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      move_q    <= move_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
      x_score_q <= x_score_d;
      o_score_q <= o_score_d;
    end
  end

  assign a1        = cells_q[0];
  assign a2        = cells_q[1];
  assign a3        = cells_q[2];
  assign a4        = cells_q[3];
  assign a5        = cells_q[4];
  assign a6        = cells_q[5];
  assign a7        = cells_q[6];
  assign a8        = cells_q[7];
  assign a9        = cells_q[8];
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = (state_q == StWin) || (state_q == StDraw);
  assign illegal   = illegal_q;
  assign x_score   = x_score_q;
  assign o_score   = o_score_q;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Directed bench for ttt_game_controller: per-cycle vector table plus hand-written corner sequences.
// Expected highlight cells follow TTT_WIN_HIGHLIGHT_EN.
module tb_ttt_game_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [1:0] turn, winner;
  logic       game_over, illegal;
  logic [3:0] x_score, o_score;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef TTT_WIN_HIGHLIGHT_EN
  localparam logic [8:0] HlRow1 = 9'b000000111;
  localparam logic [8:0] HlDiag = 9'b001010100;
`else
  localparam logic [8:0] HlRow1 = 9'b000000000;
  localparam logic [8:0] HlDiag = 9'b000000000;
`endif

  ttt_game_controller dut (
    .clock    (clock),
    .reset    (reset),
    .key_valid(key_valid),
    .key_code (key_code),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .a4       (a4),
    .a5       (a5),
    .a6       (a6),
    .a7       (a7),
    .a8       (a8),
    .a9       (a9),
    .turn     (turn),
    .winner   (winner),
    .game_over(game_over),
    .illegal  (illegal),
    .x_score  (x_score),
    .o_score  (o_score)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       kv;
    logic [3:0] code;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Board bit i is cell i+1; highlight bits override X/O.
  function automatic logic [17:0] bd(input logic [8:0] xb, input logic [8:0] ob,
                                     input logic [8:0] hb);
    logic [17:0] r;
    for (int i = 0; i < 9; i++) begin
      r[2*i +: 2] = hb[i] ? 2'b11 : xb[i] ? 2'b01 : ob[i] ? 2'b10 : 2'b00;
    end
    return r;
  endfunction

  function automatic logic [31:0] obs();
    return {a9, a8, a7, a6, a5, a4, a3, a2, a1, turn, winner, game_over, illegal,
            x_score, o_score};
  endfunction

  task automatic add(input logic kv, input logic [3:0] code, input logic [8:0] xb,
                     input logic [8:0] ob, input logic [8:0] hb, input logic [1:0] t,
                     input logic [1:0] w, input logic g, input logic il,
                     input logic [3:0] xs, input logic [3:0] os);
    vec_t v;
    v.kv   = kv;
    v.code = code;
    v.exp  = {bd(xb, ob, hb), t, w, g, il, xs, os};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic kv, input logic [3:0] code);
    key_valid = kv;
    key_code  = code;
    @(posedge clock);
    @(negedge clock);
  endtask

  localparam logic [31:0] ResetExp = {18'b0, 2'b01, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0};
  localparam logic [8:0]  Z = 9'b0;

  initial begin
    // X wins on the top row, then restart behaviour.
    add(1, 1, 9'b000000001, Z, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000001, Z, Z, 2'b10, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000001, Z, Z, 2'b10, 2'b00, 0, 0, 0, 0);
    add(1, 4, 9'b000000001, 9'b000001000, Z, 2'b10, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000001, 9'b000001000, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000001, 9'b000001000, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(1, 2, 9'b000000011, 9'b000001000, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000011, 9'b000001000, Z, 2'b10, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000011, 9'b000001000, Z, 2'b10, 2'b00, 0, 0, 0, 0);
    add(1, 5, 9'b000000011, 9'b000011000, Z, 2'b10, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000011, 9'b000011000, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000011, 9'b000011000, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(1, 3, 9'b000000111, 9'b000011000, Z, 2'b01, 2'b00, 0, 0, 0, 0);
    add(0, 0, 9'b000000111, 9'b000011000, HlRow1, 2'b00, 2'b01, 1, 0, 1, 0);
    add(0, 0, 9'b000000111, 9'b000011000, HlRow1, 2'b00, 2'b01, 1, 0, 1, 0);
    add(1, 7, 9'b000000111, 9'b000011000, HlRow1, 2'b00, 2'b01, 1, 0, 1, 0);
    add(1, 0, Z, Z, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    // Occupied cell, restart key and out-of-range key in PLAY, then a dropped fast strobe.
    add(1, 5, 9'b000010000, Z, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    add(0, 0, 9'b000010000, Z, Z, 2'b10, 2'b00, 0, 0, 1, 0);
    add(1, 5, 9'b000010000, Z, Z, 2'b10, 2'b00, 0, 1, 1, 0);
    add(0, 0, 9'b000010000, Z, Z, 2'b10, 2'b00, 0, 0, 1, 0);
    add(1, 0, 9'b000010000, Z, Z, 2'b10, 2'b00, 0, 1, 1, 0);
    add(1, 12, 9'b000010000, Z, Z, 2'b10, 2'b00, 0, 1, 1, 0);
    add(0, 0, 9'b000010000, Z, Z, 2'b10, 2'b00, 0, 0, 1, 0);
    add(1, 1, 9'b000010000, 9'b000000001, Z, 2'b10, 2'b00, 0, 0, 1, 0);
    add(1, 2, 9'b000010000, 9'b000000001, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    add(0, 0, 9'b000010000, 9'b000000001, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    add(1, 3, 9'b000010100, 9'b000000001, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    add(0, 0, 9'b000010100, 9'b000000001, Z, 2'b10, 2'b00, 0, 0, 1, 0);
    add(1, 2, 9'b000010100, 9'b000000011, Z, 2'b10, 2'b00, 0, 0, 1, 0);
    add(0, 0, 9'b000010100, 9'b000000011, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    add(1, 7, 9'b001010100, 9'b000000011, Z, 2'b01, 2'b00, 0, 0, 1, 0);
    add(0, 0, 9'b001010100, 9'b000000011, HlDiag, 2'b00, 2'b01, 1, 0, 2, 0);
    add(1, 0, Z, Z, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    // Full board with no line: draw.
    add(1, 1, 9'b000000001, Z, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b000000001, Z, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(1, 2, 9'b000000001, 9'b000000010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b000000001, 9'b000000010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(1, 3, 9'b000000101, 9'b000000010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b000000101, 9'b000000010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(1, 5, 9'b000000101, 9'b000010010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b000000101, 9'b000010010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(1, 4, 9'b000001101, 9'b000010010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b000001101, 9'b000010010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(1, 6, 9'b000001101, 9'b000110010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b000001101, 9'b000110010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(1, 8, 9'b010001101, 9'b000110010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b010001101, 9'b000110010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(1, 7, 9'b010001101, 9'b001110010, Z, 2'b10, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b010001101, 9'b001110010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(1, 9, 9'b110001101, 9'b001110010, Z, 2'b01, 2'b00, 0, 0, 2, 0);
    add(0, 0, 9'b110001101, 9'b001110010, Z, 2'b00, 2'b00, 1, 0, 2, 0);
    add(1, 5, 9'b110001101, 9'b001110010, Z, 2'b00, 2'b00, 1, 0, 2, 0);
    add(1, 0, Z, Z, Z, 2'b01, 2'b00, 0, 0, 2, 0);

    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    @(posedge clock);
    @(negedge clock);
    check("reset_state", obs(), ResetExp);
    reset = 1'b0;
    step(0, 0);
    check("idle_after_reset", obs(), ResetExp);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].kv, vecs[i].code);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    step(0, 0);

    // O wins on the middle row.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    begin
      logic [3:0] keys [6];
      keys = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd9, 4'd6};
      for (int k = 0; k < 6; k++) begin
        step(1, keys[k]);
        step(0, 0);
      end
    end
    check("o_win_winner", 32'(winner), 32'(2'b10));
    check("o_win_score", 32'({x_score, o_score}), 32'({4'd0, 4'd1}));
    step(1, 0);

    // Ten X wins from a clean reset: score saturates at 9.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int g = 0; g < 10; g++) begin
      logic [3:0] keys [5];
      keys = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
      for (int k = 0; k < 5; k++) begin
        step(1, keys[k]);
        step(0, 0);
      end
      check($sformatf("x_score_game%0d", g), 32'(x_score), (g < 9) ? g + 1 : 9);
      step(1, 0);
    end

    // Reset asserted while the move is being checked.
    step(1, 1);
    key_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("reset_mid_check", obs(), ResetExp);
    @(negedge clock);
    reset = 1'b0;
    step(0, 0);
    check("play_after_reset", obs(), ResetExp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ttt_game_controller.md
# ttt_game_controller

Turn sequencer for the tic-tac-toe board. Accepts decoded keypad presses, writes the nine 2-bit grid cells `a1`..`a9` that feed the VGA display, alternates players, detects win and draw, and keeps per-player win tallies for the seven-segment digits. It is the only writer of the grid; display blocks read it combinationally.

## Interface

- `RESTART_KEY`, default 4'd0, key code that clears the board after a finished game.
- `SCORE_MAX`, default 4'd9, saturation value of each win counter.

- `clock`  in  1  system clock (MAX10_CLK1_50 domain)
- `reset`  in  1  asynchronous, active-high; clears all state
- `key_valid`  in  1  one-cycle strobe, key_code valid
- `key_code`  in  4  1..9 = cell number (row-major, 1 top-left), else other keys
- `a1`..`a9`  out  2 each  cell: 00 empty, 01 X, 10 O, 11 highlight (macro only)
- `turn`  out  2  player to move: 01 X, 10 O; 00 when game over
- `winner`  out  2  00 none/draw, 01 X, 10 O
- `game_over`  out  1  high in WIN or DRAW
- `illegal`  out  1  one-cycle pulse on a rejected move
- `x_score`, `o_score`  out  4 each  saturating win counts

## Operation

- States: PLAY, CHECK, WIN, DRAW. Reset → PLAY, all cells 00, `turn`=01, `winner`=00, scores 0, move count 0, `illegal`=0.
- PLAY: on `key_valid` with `key_code` in 1..9 and addressed cell 00 → write `turn` into cell, increment 4-bit move count, go CHECK.
- PLAY: `key_valid` with `key_code` 0 or 10..15, or occupied cell → no write, `illegal`=1 for one cycle, stay PLAY. Exception: `key_code`==`RESTART_KEY` in PLAY is also illegal (no mid-game restart except reset).
- CHECK: evaluate 8 lines (3 rows, 3 cols, 2 diagonals) for three equal non-zero cells.
  - Line found → WIN; `winner`=`turn`; increment that player's score unless already `SCORE_MAX`; `turn`=00.
  - Else move count == 9 → DRAW; `winner`=00; `turn`=00.
  - Else toggle `turn` (01↔10), return PLAY.
- `key_valid` during CHECK is ignored silently (no `illegal`).
- WIN/DRAW: `key_valid` with `key_code`==`RESTART_KEY` → clear cells, move count 0, `winner`=00, `turn`=01, go PLAY; scores retained. Any other key ignored silently.
- A ninth move that completes a line is a WIN, never DRAW.
- `game_over` = (state == WIN) | (state == DRAW), decoded from registered state.

## Timing

- All outputs registered; reset asynchronous, release synchronous to `clock`.
- Move strobe at edge N → cell and move count updated at N+1 (state CHECK) → `winner`/`turn`/`game_over`/score updated at N+2.
- Minimum spacing between accepted moves: 2 cycles; a strobe at N+1 is dropped.
- `illegal` asserted the cycle after the offending strobe, exactly one cycle wide.
- Restart strobe at N → board cleared and state PLAY at N+1.
- Reset asserted any time (including CHECK) → all outputs to reset values immediately, scores cleared.

## Configuration

- `TTT_WIN_HIGHLIGHT_EN` defined: on entry to WIN, the three cells of the first winning line found (priority rows top→bottom, cols left→right, diag 1-5-9, diag 3-5-7) are rewritten to 11 at the same edge as `winner`; restart clears them.
- Undefined: cells keep 01/10 in WIN; code 11 never appears on `a1`..`a9`.

## Test plan

- Reset, then keys 1,4,2,5,3 spaced 3 cycles → after last move+2: `winner`=01, `x_score`=1, `turn`=00, `game_over`=1; with macro `a1`=`a2`=`a3`=11.
- Key 5 then key 5 again → second press gives `illegal` one cycle, `a5` stays 01, `turn` stays 10.
- Keys 1,2,3,5,4,6,8,7,9 (no line) → DRAW, `winner`=00, scores unchanged, `game_over`=1.
- Two strobes on consecutive cycles (keys 1, 2) → only `a1`=01 written, `a2`=00, no `illegal`.
- After a WIN press key 7, then key 0 → key 7 ignored; after key 0 all cells 00, `turn`=01, `x_score` retained.
- Ten X wins in a row → `x_score` saturates at 9; assert `reset` mid-CHECK → all cells 00, scores 0, `turn`=01 immediately.
